// File: rtl/gecko_pkg.sv
// Shared types for the gecko print path: the print byte, the line terminator
// and the arbiter state encoding.
package gecko_pkg;

  typedef logic [7:0] print_byte_t;

  localparam print_byte_t NEWLINE = 8'h0A;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/gecko_print_fifo.sv
// Synchronous FIFO with registered pointers and an occupancy count; writes
// while full and reads while empty are ignored.
module gecko_print_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gecko_print_arbiter.sv
// Merges per-core print byte streams into one output, granting whole lines
// (or MAX_BURST-byte chunks) round-robin so lines never interleave.
// Handshakes: a byte transfers on a rising edge where valid and ready are both
// high; valid never waits on ready, and a source holds data stable while valid && !ready.
module gecko_print_arbiter
  import gecko_pkg::*;
#(
  parameter  int NUM_CHANNELS = 4,
  parameter  int FIFO_DEPTH   = 8,
  parameter  int MAX_BURST    = 64,
  localparam int CH_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CHANNELS-1:0]   in_print_valid,
  output logic [NUM_CHANNELS-1:0]   in_print_ready,
  input  logic [8*NUM_CHANNELS-1:0] in_print_data,
  input  logic [NUM_CHANNELS-1:0]   in_faulted,
  input  logic [NUM_CHANNELS-1:0]   in_finished,
  output logic                      out_print_valid,
  input  logic                      out_print_ready,
  output logic [7:0]                out_print_data,
  output logic [CH_WIDTH-1:0]       out_print_channel,
  output logic                      out_print_last,
  output logic [NUM_CHANNELS-1:0]   faulted_mask,
  output logic [NUM_CHANNELS-1:0]   finished_mask,
  output logic                      faulted_flag,
  output logic                      finished_flag,
  output arb_state_t                dbg_state
);

  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t                   state, state_next;
  logic [CH_WIDTH-1:0]          grant, last_grant, search_sel, cand, pop_sel;
  logic [BW-1:0]                burst_cnt, cnt_cur;
  logic                         any_data, avail, pop, pop_last, all_drained;
  logic [NUM_CHANNELS-1:0]      fifo_full, fifo_empty, fifo_wr, fifo_rd;
  print_byte_t                  fifo_data  [NUM_CHANNELS];
  logic [$clog2(FIFO_DEPTH):0]  fifo_level [NUM_CHANNELS];

  // Ready is forced low while rst is asserted so nothing is accepted in the reset cycle.
  assign in_print_ready = ~fifo_full & {NUM_CHANNELS{~rst}};
  assign dbg_state      = state;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    assign fifo_wr[i] = in_print_valid[i] && in_print_ready[i];
    assign fifo_rd[i] = pop && (pop_sel == CH_WIDTH'(i));
    gecko_print_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (fifo_wr[i]),
      .wr_data (in_print_data[8*i +: 8]),
      .rd_en   (fifo_rd[i]),
      .rd_data (fifo_data[i]),
      .full    (fifo_full[i]),
      .empty   (fifo_empty[i]),
      .count   (fifo_level[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    any_data    = |(~fifo_empty);
    search_sel  = '0;
    cand        = '0;
    all_drained = 1'b1;
    // Walk downwards so the closest channel after last_grant wins.
    for (int k = NUM_CHANNELS; k >= 1; k--) begin
      cand = CH_WIDTH'((int'(last_grant) + k) % NUM_CHANNELS);
      if (!fifo_empty[cand]) search_sel = cand;
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (fifo_level[i] != '0) all_drained = 1'b0;
    end
    if (state == ARB_IDLE) begin
      pop_sel = search_sel;
      avail   = any_data;
      cnt_cur = '0;
    end else begin
      pop_sel = grant;
      avail   = !fifo_empty[grant];
      cnt_cur = burst_cnt;
    end
    pop      = avail && (!out_print_valid || out_print_ready);
    pop_last = pop && ((fifo_data[pop_sel] == NEWLINE) || (cnt_cur == BW'(MAX_BURST - 1)));
    state_next = state;
    if (pop_last)                          state_next = ARB_IDLE;
    else if (state == ARB_IDLE && any_data) state_next = ARB_LOCKED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant             <= '0;
      last_grant        <= CH_WIDTH'(NUM_CHANNELS - 1);
      burst_cnt         <= '0;
      out_print_valid   <= 1'b0;
      out_print_data    <= '0;
      out_print_channel <= '0;
      out_print_last    <= 1'b0;
      faulted_mask      <= '0;
      finished_mask     <= '0;
      faulted_flag      <= 1'b0;
      finished_flag     <= 1'b0;
    end else begin
      if (state == ARB_IDLE && any_data) begin
        grant      <= pop_sel;
        last_grant <= pop_sel;
      end
      if (pop) begin
        burst_cnt         <= pop_last ? '0 : cnt_cur + 1'b1;
        out_print_valid   <= 1'b1;
        out_print_data    <= fifo_data[pop_sel];
        out_print_channel <= pop_sel;
        out_print_last    <= pop_last;
      end else if (out_print_ready) begin
        out_print_valid <= 1'b0;
      end
      faulted_mask  <= faulted_mask | in_faulted;
      finished_mask <= finished_mask | in_finished;
      faulted_flag  <= |(faulted_mask | in_faulted);
      finished_flag <= (&finished_mask) && all_drained && !out_print_valid;
    end
  end

endmodule

// File: tb/tb_gecko_print_arbiter.sv
// Bench for gecko_print_arbiter: queue-based reference model compared every
// cycle, directed line/burst/status scenarios, then randomized traffic.
module tb_gecko_print_arbiter;
  import gecko_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int MAXB  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   in_valid = '0;
  logic [8*N-1:0] in_data = '0;
  logic [N-1:0]   in_faulted = '0;
  logic [N-1:0]   in_finished = '0;
  logic           out_ready = 1'b0;
  logic [N-1:0]   in_ready;
  logic           out_valid, out_last, fflag, dflag;
  logic [7:0]     out_data;
  logic [1:0]     out_channel;
  logic [N-1:0]   fmask, dmask;
  arb_state_t     dbg_state;

  gecko_print_arbiter #(.NUM_CHANNELS(N), .FIFO_DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .in_print_valid(in_valid), .in_print_ready(in_ready), .in_print_data(in_data),
    .in_faulted(in_faulted), .in_finished(in_finished),
    .out_print_valid(out_valid), .out_print_ready(out_ready), .out_print_data(out_data),
    .out_print_channel(out_channel), .out_print_last(out_last),
    .faulted_mask(fmask), .finished_mask(dmask),
    .faulted_flag(fflag), .finished_flag(dflag), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  mq [N][$];
  logic [15:0] exp_q [$];
  int          m_last, m_grant, m_cnt;
  bit          m_locked;
  logic        m_ov, m_ol, m_ff, m_df;
  logic [7:0]  m_od;
  logic [1:0]  m_oc;
  logic [N-1:0] m_fm, m_dm;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    int  sz [N];
    bit  all_empty, new_df, have;
    int  src;
    logic [7:0] b;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_locked = 0; m_last = N - 1; m_grant = 0; m_cnt = 0;
      m_ov = 0; m_ol = 0; m_od = 0; m_oc = 0;
      m_fm = 0; m_dm = 0; m_ff = 0; m_df = 0;
      return;
    end
    all_empty = 1;
    for (int i = 0; i < N; i++) begin
      sz[i] = mq[i].size();
      if (sz[i] != 0) all_empty = 0;
    end
    new_df = (&m_dm) && all_empty && !m_ov;
    if (m_ov && out_ready) exp_q.push_back({3'b0, m_ol, 2'b0, m_oc, m_od});
    have = 0;
    src  = m_grant;
    if (!m_locked) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!have && sz[c] > 0) begin have = 1; src = c; end
      end
      if (have) begin m_locked = 1; m_grant = src; m_last = src; m_cnt = 0; end
    end else begin
      have = sz[m_grant] > 0;
    end
    if (have && (!m_ov || out_ready)) begin
      b = mq[src].pop_front();
      m_cnt++;
      m_ov = 1; m_od = b; m_oc = 2'(src);
      m_ol = (b == 8'h0A) || (m_cnt == MAXB);
      if (m_ol) begin m_locked = 0; m_cnt = 0; end
    end else if (out_ready) begin
      m_ov = 0;
    end
    for (int i = 0; i < N; i++)
      if (in_valid[i] && sz[i] < DEPTH) mq[i].push_back(in_data[8*i +: 8]);
    m_fm = m_fm | in_faulted;
    m_dm = m_dm | in_finished;
    m_ff = |m_fm;
    m_df = new_df;
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = !rst && (mq[i].size() < DEPTH);
    return r;
  endfunction

  // ---------------- per-cycle compare ----------------
  always begin
    @(posedge clk);
    model_step();
    #1;
    if (chk_en) begin
      chk("in_print_ready", in_ready, exp_ready());
      chk("out_print_valid", out_valid, m_ov);
      chk("out_print_data", out_data, m_od);
      chk("out_print_channel", out_channel, m_oc);
      chk("out_print_last", out_last, m_ol);
      chk("faulted_mask", fmask, m_fm);
      chk("finished_mask", dmask, m_dm);
      chk("faulted_flag", fflag, m_ff);
      chk("finished_flag", dflag, m_df);
      chk("dbg_state", dbg_state, m_locked ? ARB_LOCKED : ARB_IDLE);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_byte(input int ch, input logic [7:0] b);
    in_valid[ch] = 1'b1;
    in_data[8*ch +: 8] = b;
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_faulted = '0; in_finished = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    out_ready = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ready_low", in_ready, 4'h0);
    chk("rst_masks", {fmask, dmask, fflag, dflag}, 10'h0);
    rst = 1'b0;
    cyc();
    chk("ready_after_rst", in_ready, 4'hF);

    // Single line on channel 2, 2-cycle latency
    exp_q.delete();
    drive_byte(2, "A"); cyc();
    chk("lat_not_yet", out_valid, 1'b0);
    drive_byte(2, "B"); cyc();
    chk("first_A", {out_valid, out_last, out_channel, out_data}, {1'b1, 1'b0, 2'd2, 8'h41});
    drive_byte(2, 8'h0A); cyc();
    chk("then_B", {out_valid, out_last, out_channel, out_data}, {1'b1, 1'b0, 2'd2, 8'h42});
    idle_inputs(); cyc();
    chk("nl_last", {out_valid, out_last, out_channel, out_data}, {1'b1, 1'b1, 2'd2, 8'h0A});
    cyc();
    chk("drained", out_valid, 1'b0);
    chk("log37_len", exp_q.size(), 3);
    chk("log37_2", exp_q[2], 16'h120A);

    // Two simultaneous lines: ch0 then ch1, no interleave
    do_reset();
    drive_byte(0, "x"); drive_byte(1, "x"); cyc();
    drive_byte(0, 8'h0A); drive_byte(1, 8'h0A); cyc();
    idle_inputs(); repeat (6) cyc();
    chk("log38_len", exp_q.size(), 4);
    chk("log38_0", exp_q[0], 16'h0078);
    chk("log38_1", exp_q[1], 16'h100A);
    chk("log38_2", exp_q[2], 16'h0178);
    chk("log38_3", exp_q[3], 16'h110A);

    // Forced rotation after MAX_BURST bytes
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid = '0;
      drive_byte(3, 8'(8'h61 + i));
      if (i == 1) drive_byte(0, 8'h0A);
      cyc();
    end
    idle_inputs(); repeat (10) cyc();
    chk("log39_len", exp_q.size(), 7);
    chk("log39_3", exp_q[3], 16'h1364);
    chk("log39_4", exp_q[4], 16'h100A);
    chk("log39_5", exp_q[5], 16'h0365);
    chk("log39_6", exp_q[6], 16'h0366);

    // Backpressure: FIFO fills, output byte held
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive_byte(1, 8'(8'h30 + i));
      cyc();
      if (i >= 1) chk("held_byte", {out_valid, out_data}, {1'b1, 8'h30});
    end
    chk("full_ready1", in_ready[1], 1'b0);
    chk("fifo1_level", mq[1].size(), 8);
    idle_inputs(); out_ready = 1'b1;
    repeat (14) cyc();

    // finished_flag waits for the drain
    do_reset();
    out_ready = 1'b0;
    drive_byte(0, "1"); cyc();
    drive_byte(0, "2"); in_finished = 4'hF; cyc();
    in_finished = '0;
    drive_byte(0, "3"); cyc();
    idle_inputs(); cyc();
    chk("fin_mask", dmask, 4'hF);
    chk("fin_wait", dflag, 1'b0);
    out_ready = 1'b1;
    cyc(); chk("fin_wait1", dflag, 1'b0);
    cyc(); chk("fin_wait2", dflag, 1'b0);
    cyc(); chk("fin_wait3", {dflag, out_valid}, 2'b00);
    cyc(); chk("fin_rise", dflag, 1'b1);

    // Fault pulse then reset mid-burst
    do_reset();
    drive_byte(2, "a"); cyc();
    drive_byte(2, "b"); cyc();
    drive_byte(2, "c"); in_faulted = 4'b0010; cyc();
    in_faulted = '0;
    chk("fault_flag", {fflag, fmask}, {1'b1, 4'b0010});
    out_ready = 1'b0;
    rst = 1'b1; cyc();
    chk("rst_clear", {out_valid, out_last, out_data, out_channel, fmask, dmask, fflag, dflag},
        20'h0);
    rst = 1'b0; idle_inputs(); out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("no_stale", out_valid, 1'b0);
    end

    // Randomized traffic
    do_reset();
    repeat (3000) begin
      rst = ($urandom_range(0, 599) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        in_valid[i] = $urandom_range(0, 1);
        in_data[8*i +: 8] = ($urandom_range(0, 5) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
        in_faulted[i]  = ($urandom_range(0, 199) == 0);
        in_finished[i] = ($urandom_range(0, 199) == 0);
      end
      cyc();
    end
    rst = 1'b0; idle_inputs(); out_ready = 1'b1;
    repeat (50) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
